sc_load_arbiter: RTL and testbench

Arbitrates access to the Microroc slow-control (SC) load engine between two requesters: the host command path (USB register writes) and the sweep-acquisition controller. It latches the winning requester's DAC0/DAC1/DAC2 set, drives the bit-reversed values to the SC engine, and issues a one-cycle load strobe. It then waits for the engine's done signal and a fixed settle time, and acknowledges the requester. It sits between the command decoder and sweep controller on one side and the SC shift-register engine on the other.

---
 rtl/sc_load_arbiter.sv | 116 +++++++++++
 tb/tb_sc_load_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sc_load_arbiter.sv
// Round-robin arbiter between host and sweep for the SC load engine: latch DACs, strobe, await done + settle, ack.
// Grant 1 cycle after request; strobe in cycle 2; ack SETTLE_CYCLES+1 after done edge (or TIMEOUT_CYCLES+1 into WAIT_DONE).
module sc_load_arbiter #(
  parameter logic [15:0] SETTLE_CYCLES  = 16'd40_000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       HostLoadReq,
  input  logic [9:0] HostDAC0,
  input  logic [9:0] HostDAC1,
  input  logic [9:0] HostDAC2,
  output logic       HostLoadAck,
  input  logic       SweepLoadReq,
  input  logic [9:0] SweepDAC0,
  input  logic [9:0] SweepDAC1,
  input  logic [9:0] SweepDAC2,
  output logic       SweepLoadAck,
  output logic [9:0] OutDAC0,
  output logic [9:0] OutDAC1,
  output logic [9:0] OutDAC2,
  output logic       LoadSCParameter,
  input  logic       MicrorocConfigDone,
  output logic       Busy,
  output logic       GrantId,
  output logic       LoadTimeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRANT  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        last_grant;
  logic        done_prev;
  logic        done_evt;
  logic        timeout_hit;
  logic        winner;
  logic [15:0] settle_cnt;
  logic [19:0] timeout_cnt;

  function automatic logic [9:0] bit_rev(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  // Only a fresh 0->1 transition counts; a level already high is ignored.
  assign done_evt    = MicrorocConfigDone & ~done_prev;
  assign timeout_hit = (state == S_WAIT) && !done_evt && (timeout_cnt == TIMEOUT_CYCLES);

  always_comb begin
    winner = SweepLoadReq;
    if (HostLoadReq && SweepLoadReq) winner = ~last_grant;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (HostLoadReq || SweepLoadReq) next_state = S_GRANT;
      S_GRANT:  next_state = S_LOAD;
      S_LOAD, S_WAIT: begin
        if (done_evt)
          next_state = (SETTLE_CYCLES == 16'd0) ? S_ACK : S_SETTLE;
        else if (timeout_hit)
          next_state = S_ACK;
        else
          next_state = S_WAIT;
      end
      S_SETTLE: if (settle_cnt == SETTLE_CYCLES - 16'd1) next_state = S_ACK;
      S_ACK:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      last_grant      <= 1'b1;
      done_prev       <= 1'b0;
      settle_cnt      <= 16'd0;
      timeout_cnt     <= 20'd0;
      OutDAC0         <= 10'd0;
      OutDAC1         <= 10'd0;
      OutDAC2         <= 10'd0;
      LoadSCParameter <= 1'b0;
      HostLoadAck     <= 1'b0;
      SweepLoadAck    <= 1'b0;
      Busy            <= 1'b0;
      GrantId         <= 1'b0;
      LoadTimeout     <= 1'b0;
    end else begin
      state           <= next_state;
      done_prev       <= MicrorocConfigDone;
      settle_cnt      <= (state == S_SETTLE) ? settle_cnt + 16'd1 : 16'd0;
      timeout_cnt     <= (state == S_WAIT) ? timeout_cnt + 20'd1 : 20'd0;
      LoadSCParameter <= (next_state == S_LOAD);
      Busy            <= (next_state != S_IDLE);
      HostLoadAck     <= (next_state == S_ACK) && !GrantId;
      SweepLoadAck    <= (next_state == S_ACK) && GrantId;
      LoadTimeout     <= timeout_hit;
      if (state == S_IDLE && next_state == S_GRANT) begin
        GrantId <= winner;
        OutDAC0 <= bit_rev(winner ? SweepDAC0 : HostDAC0);
        OutDAC1 <= bit_rev(winner ? SweepDAC1 : HostDAC1);
        OutDAC2 <= bit_rev(winner ? SweepDAC2 : HostDAC2);
      end
      if (state == S_ACK) last_grant <= GrantId;
    end
  end

endmodule

// File: tb/tb_sc_load_arbiter.sv
// Randomized transaction-level bench for sc_load_arbiter (SETTLE_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_sc_load_arbiter;
  localparam int S = 4;
  localparam int T = 20;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       HostLoadReq, SweepLoadReq, MicrorocConfigDone;
  logic [9:0] HostDAC0, HostDAC1, HostDAC2;
  logic [9:0] SweepDAC0, SweepDAC1, SweepDAC2;
  logic       HostLoadAck, SweepLoadAck, LoadSCParameter, Busy, GrantId, LoadTimeout;
  logic [9:0] OutDAC0, OutDAC1, OutDAC2;

  int checks = 0;
  int errors = 0;
  bit last_grant;

  always #5 Clk = ~Clk;

  sc_load_arbiter #(.SETTLE_CYCLES(16'd4), .TIMEOUT_CYCLES(20'd20)) dut (
    .Clk(Clk), .reset_n(reset_n),
    .HostLoadReq(HostLoadReq), .HostDAC0(HostDAC0), .HostDAC1(HostDAC1), .HostDAC2(HostDAC2),
    .HostLoadAck(HostLoadAck),
    .SweepLoadReq(SweepLoadReq), .SweepDAC0(SweepDAC0), .SweepDAC1(SweepDAC1), .SweepDAC2(SweepDAC2),
    .SweepLoadAck(SweepLoadAck),
    .OutDAC0(OutDAC0), .OutDAC1(OutDAC1), .OutDAC2(OutDAC2),
    .LoadSCParameter(LoadSCParameter), .MicrorocConfigDone(MicrorocConfigDone),
    .Busy(Busy), .GrantId(GrantId), .LoadTimeout(LoadTimeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] rev(input logic [9:0] v);
    logic [9:0] r;
    r = {<<{v}};
    return r;
  endfunction

  task automatic rand_dacs();
    HostDAC0  = 10'($urandom_range(0, 1023));
    HostDAC1  = 10'($urandom_range(0, 1023));
    HostDAC2  = 10'($urandom_range(0, 1023));
    SweepDAC0 = 10'($urandom_range(0, 1023));
    SweepDAC1 = 10'($urandom_range(0, 1023));
    SweepDAC2 = 10'($urandom_range(0, 1023));
  endtask

  // Called at a negedge while the DUT is idle; cycle k is the k-th cycle after the sampling edge.
  // done_cyc < 0 means no fresh done edge (timeout expected).
  task automatic txn(input string tag, input bit set_h, input bit set_s, input bit hold,
                     input int done_cyc, input bit done_level, input bit pre_high, input bit rnd);
    bit win, exp_to, ack_who, to_at_ack, busy_at_ack;
    logic [9:0] e0, e1, e2;
    int exp_ack, strobes, strobe_cyc, ack_cyc, both_ack, to_cnt;
    strobes = 0; strobe_cyc = -1; ack_cyc = -1; both_ack = 0; to_cnt = 0;
    ack_who = 1'b0; to_at_ack = 1'b0; busy_at_ack = 1'b0;
    if (rnd) rand_dacs();
    if (set_h) HostLoadReq = 1'b1;
    if (set_s) SweepLoadReq = 1'b1;
    win = (HostLoadReq && SweepLoadReq) ? ~last_grant : SweepLoadReq;
    e0 = win ? rev(SweepDAC0) : rev(HostDAC0);
    e1 = win ? rev(SweepDAC1) : rev(HostDAC1);
    e2 = win ? rev(SweepDAC2) : rev(HostDAC2);
    exp_to  = (done_cyc < 0);
    exp_ack = exp_to ? 3 + T + 1 : done_cyc + 1 + S;
    MicrorocConfigDone = pre_high;
    for (int k = 1; k <= 60 && ack_cyc < 0; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        check_val({tag, ".grant_busy"}, 32'(Busy), 32'd1);
        check_val({tag, ".grant_id"}, 32'(GrantId), 32'(win));
        check_val({tag, ".dac0"}, 32'(OutDAC0), 32'(e0));
        check_val({tag, ".dac1"}, 32'(OutDAC1), 32'(e1));
        check_val({tag, ".dac2"}, 32'(OutDAC2), 32'(e2));
        if (rnd) rand_dacs();
      end
      if (LoadSCParameter) begin
        strobes++;
        if (strobe_cyc < 0) strobe_cyc = k;
      end
      if (LoadTimeout) to_cnt++;
      if (HostLoadAck || SweepLoadAck) begin
        ack_cyc = k; ack_who = SweepLoadAck; to_at_ack = LoadTimeout; busy_at_ack = Busy;
        if (HostLoadAck && SweepLoadAck) both_ack++;
        if (!hold) begin
          if (SweepLoadAck) SweepLoadReq = 1'b0;
          else HostLoadReq = 1'b0;
        end
      end
      if (done_cyc < 0)       MicrorocConfigDone = pre_high;
      else if (k == done_cyc) MicrorocConfigDone = 1'b1;
      else if (k < done_cyc)  MicrorocConfigDone = pre_high && (k < done_cyc - 1);
      else                    MicrorocConfigDone = done_level;
    end
    @(negedge Clk);
    MicrorocConfigDone = 1'b0;
    check_val({tag, ".ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
    check_val({tag, ".ack_who"}, 32'(ack_who), 32'(win));
    check_val({tag, ".both_acks"}, 32'(both_ack), 32'd0);
    check_val({tag, ".timeout_at_ack"}, 32'(to_at_ack), 32'(exp_to));
    check_val({tag, ".timeout_pulses"}, 32'(to_cnt), 32'(exp_to));
    check_val({tag, ".strobes"}, 32'(strobes), 32'd1);
    check_val({tag, ".strobe_cycle"}, 32'(strobe_cyc), 32'd2);
    check_val({tag, ".busy_at_ack"}, 32'(busy_at_ack), 32'd1);
    check_val({tag, ".busy_after"}, 32'(Busy), 32'd0);
    check_val({tag, ".acks_after"}, 32'({HostLoadAck, SweepLoadAck}), 32'd0);
    check_val({tag, ".dac_hold"}, 32'({OutDAC0, OutDAC1, OutDAC2}), 32'({e0, e1, e2}));
    last_grant = win;
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    reset_n = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    last_grant = 1'b1;
  endtask

  initial begin
    int dc, act;
    bit sh, ss;
    reset_n = 1'b0;
    HostLoadReq = 1'b0; SweepLoadReq = 1'b0; MicrorocConfigDone = 1'b0;
    HostDAC0 = '0; HostDAC1 = '0; HostDAC2 = '0;
    SweepDAC0 = '0; SweepDAC1 = '0; SweepDAC2 = '0;
    last_grant = 1'b1;
    #12;
    check_val("rst.outs", 32'({LoadSCParameter, HostLoadAck, SweepLoadAck, Busy, GrantId, LoadTimeout}), 32'd0);
    check_val("rst.dacs", 32'({OutDAC0, OutDAC1, OutDAC2}), 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);

    HostDAC0 = 10'h001; HostDAC1 = 10'h155; HostDAC2 = 10'h3FF;
    SweepDAC0 = 10'h0F0; SweepDAC1 = 10'h00F; SweepDAC2 = 10'h123;
    txn("host_alone", 1, 0, 0, 7, 0, 0, 0);
    check_val("host_alone.vec", 32'({OutDAC0, OutDAC1, OutDAC2}), 32'({10'h200, 10'h2AA, 10'h3FF}));

    pulse_reset();
    txn("tie_first", 1, 1, 0, 5, 0, 0, 1);
    txn("tie_second", 0, 0, 0, 4, 1, 0, 1);

    for (int i = 0; i < 4; i++) txn("held_rr", 1, 1, 1, 2 + i, 0, 0, 1);
    HostLoadReq = 1'b0; SweepLoadReq = 1'b0;

    txn("timeout", 1, 0, 0, -1, 0, 0, 1);
    txn("done_prehigh", 0, 1, 0, 10, 1, 1, 1);
    txn("prehigh_timeout", 1, 0, 0, -1, 0, 1, 1);

    for (int i = 0; i < 12; i++) begin
      sh = 1'($urandom_range(0, 1));
      ss = sh ? 1'($urandom_range(0, 1)) : 1'b1;
      dc = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, 20));
      txn("rand", sh, ss, 0, dc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
    for (int i = 0; i < 2; i++)
      if (HostLoadReq || SweepLoadReq) txn("drain", 0, 0, 0, 6, 0, 0, 1);

    txn("pre_rst", 1, 0, 0, 4, 0, 0, 1);

    // Reset during SETTLE (done edge at cycle 5, settle cycles 6..9).
    HostDAC0 = 10'h3C1;
    HostLoadReq = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      MicrorocConfigDone = (k == 5);
    end
    check_val("mid_rst.busy_before", 32'(Busy), 32'd1);
    reset_n = 1'b0;
    HostLoadReq = 1'b0;
    #1;
    check_val("mid_rst.outs", 32'({LoadSCParameter, HostLoadAck, SweepLoadAck, Busy, GrantId, LoadTimeout}), 32'd0);
    check_val("mid_rst.dacs", 32'({OutDAC0, OutDAC1, OutDAC2}), 32'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    last_grant = 1'b1;
    act = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge Clk);
      if (HostLoadAck || SweepLoadAck || Busy) act++;
    end
    check_val("mid_rst.no_ack", 32'(act), 32'd0);
    txn("post_rst_tie", 1, 1, 0, 5, 0, 0, 1);
    txn("post_rst_sweep", 0, 0, 0, 3, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
